pipe_stage_skid: RTL
====================

// Module: pipe_stage_skid
// PURPOSE
//  Parametrised inter-stage pipeline register for the RV32 core (IF/ID, ID/EX, EX/MEM, MEM/WB).
//  Carries a payload bus plus a control bus with valid/ready handshake, global stall (busywait) and flush (branch/jump kill).
//  Optional 2-entry skid buffer lets the upstream stage keep issuing for one cycle after downstream back-pressure.
//  Saturating stall/flush event counters feed the cache-switching performance study.
// PARAMETERS
//  DATA_W     192  payload width (pc, pc+4, operands, imm, ...); not cleared on flush unless CLR_DATA=1
//  CTRL_W     24   control width (mem r/w, reg-write en, mux selects, alu_op, fun3, ...); always cleared on flush
//  SKID       1    0 = single register, 1 = main + skid register (2 entries)
//  CLR_DATA   1    1 = flush/reset also zeroes stored payload, 0 = payload only invalidated
//  CNT_W      16   width of the stall and flush counters
// PORTS
//  clk        in   1       rising-edge clock
//  reset      in   1       asynchronous active-low reset (0 = reset)
//  stall      in   1       global busywait; freezes the stage
//  flush      in   1       branch/jump kill; discards all held entries
//  in_valid   in   1       upstream entry valid
//  in_ready   out  1       stage can accept this cycle (combinational)
//  in_data    in   DATA_W  upstream payload
//  in_ctrl    in   CTRL_W  upstream control
//  out_valid  out  1       main entry valid (registered)
//  out_ready  in   1       downstream accepts
//  out_data   out  DATA_W  main-entry payload
//  out_ctrl   out  CTRL_W  main-entry control; 0 whenever out_valid=0
//  occupancy  out  2       entries held: 0, 1 or 2
//  cnt_clr    in   1       synchronous clear of both counters
//  stall_cnt  out  CNT_W   cycles with stall=1 and flush=0; saturates at all-ones
//  flush_cnt  out  CNT_W   cycles with flush=1 and at least one valid entry; saturates at all-ones
// BEHAVIOUR
//  Storage: main register M and skid register S (S exists only when SKID=1), each with a valid bit.
//  Reset (reset=0, async): M and S valid = 0, ctrl = 0, data = 0; occupancy = 0; counters = 0.
//  While reset=0: out_valid = 0 and in_ready = 0.
//  Priority per cycle: reset > flush > stall > normal.
//  in_fire  = in_valid & in_ready
//  out_fire = out_valid & out_ready & !stall & !flush
//  SKID=1: in_ready = !stall & !flush & !S.valid
//  SKID=0: in_ready = !stall & !flush & (!M.valid | out_ready)
//  SKID=1 state machine (occupancy):
//    EMPTY -> ONE : in_fire; M <= in
//    ONE   -> ONE : in_fire & out_fire; M <= in
//    ONE   -> FULL: in_fire & !out_fire; S <= in, M held
//    ONE   -> EMPTY: out_fire & !in_fire
//    FULL  -> ONE : out_fire; M <= S, S invalidated
//    In FULL, in_ready = 0.
//  SKID=0: M <= in on in_fire; M.valid <= 0 on out_fire & !in_fire; FULL unreachable.
//  Flush: next edge clears M/S valid and ctrl; clears data iff CLR_DATA=1.
//    The same-cycle input is dropped, and out_fire=0 regardless of out_ready.
//  Stall: all state frozen; out_data/out_ctrl/out_valid held; downstream must not consume.
//  Latency: entry accepted at edge N is on out_* after edge N (1 cycle); throughput 1 per cycle.
//  Order is strictly FIFO: an entry in S is always younger than the entry in M.
//  Counters: cnt_clr overrides increment; saturate at all-ones with no wrap.
//    stall and flush in the same cycle count as flush only.
//  Reset mid-operation: immediate clear independent of clk; no entry survives.
// TESTING
//  1 reset=0 with in_valid=1 -> out_valid=0, out_ctrl=0, occupancy=0, in_ready=0; release -> first entry 0xA out after 1 edge
//  2 stream 0x1..0x8, out_ready=1 -> out_data=0x1..0x8 on consecutive cycles, occupancy=1 throughout
//  3 SKID=1: out_ready=0 after 0x1, keep driving 0x2,0x3 -> occupancy=2, in_ready=0, 0x3 held; out_ready=1 -> 0x1,0x2,0x3 in order
//  4 occupancy=2 plus flush for 1 cycle with in_valid=1 (0x9) -> occupancy=0, out_ctrl=0, 0x9 lost, flush_cnt=1
//  5 stall=1 for 5 cycles with out_ready=1 -> out_* unchanged, in_ready=0, stall_cnt=5; stall+flush together -> flush_cnt+1, stall_cnt unchanged
//  6 CNT_W=4: 20 stall cycles -> stall_cnt=15 (saturated); cnt_clr=1 -> both counters 0 next edge

Source files
------------

// File: rtl/pipe_stage_skid.sv
// Inter-stage pipeline register with valid/ready handshake, stall/flush control,
// an optional two-entry skid buffer and saturating stall/flush event counters.
module pipe_stage_skid #(
    parameter int unsigned DATA_W   = 192,
    parameter int unsigned CTRL_W   = 24,
    parameter int unsigned SKID     = 1,
    parameter int unsigned CLR_DATA = 1,
    parameter int unsigned CNT_W    = 16
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              stall_i,
    input  logic              flush_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [DATA_W-1:0] in_data_i,
    input  logic [CTRL_W-1:0] in_ctrl_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [DATA_W-1:0] out_data_o,
    output logic [CTRL_W-1:0] out_ctrl_o,
    output logic [1:0]        occupancy_o,
    input  logic              cnt_clr_i,
    output logic [CNT_W-1:0]  stall_cnt_o,
    output logic [CNT_W-1:0]  flush_cnt_o
);

    // Encoding doubles as the occupancy count: M is valid in ONE/FULL, S only in FULL.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [DATA_W-1:0]   m_data_q, m_data_d;
    logic [CTRL_W-1:0]   m_ctrl_q, m_ctrl_d;
    logic [DATA_W-1:0]   s_data_q, s_data_d;
    logic [CTRL_W-1:0]   s_ctrl_q, s_ctrl_d;
    logic [CNT_W-1:0]    stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]    flush_cnt_q, flush_cnt_d;

    logic                m_valid_s;
    logic                s_valid_s;
    logic                in_ready_s;
    logic                in_fire_s;
    logic                out_fire_s;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        logic [CNT_W-1:0] r;
        if (&v) begin
            r = v;
        end else begin
            r = v + {{(CNT_W-1){1'b0}}, 1'b1};
        end
        return r;
    endfunction

    // Handshake decode; in_ready is held low while the asynchronous reset is asserted.
    always_comb begin
        m_valid_s = (state_q != ST_EMPTY);
        s_valid_s = (state_q == ST_FULL);
        if (SKID != 32'd0) begin
            in_ready_s = rst_ni & ~stall_i & ~flush_i & ~s_valid_s;
        end else begin
            in_ready_s = rst_ni & ~stall_i & ~flush_i & (~m_valid_s | out_ready_i);
        end
        in_fire_s  = in_valid_i & in_ready_s;
        out_fire_s = m_valid_s & out_ready_i & ~stall_i & ~flush_i;
    end

    // Next-state for the storage entries: flush beats stall beats normal flow.
    always_comb begin
        state_d  = state_q;
        m_data_d = m_data_q;
        m_ctrl_d = m_ctrl_q;
        s_data_d = s_data_q;
        s_ctrl_d = s_ctrl_q;
        if (flush_i) begin
            state_d  = ST_EMPTY;
            m_ctrl_d = {CTRL_W{1'b0}};
            s_ctrl_d = {CTRL_W{1'b0}};
            if (CLR_DATA != 32'd0) begin
                m_data_d = {DATA_W{1'b0}};
                s_data_d = {DATA_W{1'b0}};
            end else begin
                m_data_d = m_data_q;
                s_data_d = s_data_q;
            end
        end else if (stall_i) begin
            state_d = state_q;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (in_fire_s) begin
                        state_d  = ST_ONE;
                        m_data_d = in_data_i;
                        m_ctrl_d = in_ctrl_i;
                    end else begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_ONE: begin
                    if (in_fire_s && out_fire_s) begin
                        state_d  = ST_ONE;
                        m_data_d = in_data_i;
                        m_ctrl_d = in_ctrl_i;
                    end else if (in_fire_s && (SKID != 32'd0)) begin
                        state_d  = ST_FULL;
                        s_data_d = in_data_i;
                        s_ctrl_d = in_ctrl_i;
                    end else if (out_fire_s) begin
                        // Control must read as zero once the entry is gone.
                        state_d  = ST_EMPTY;
                        m_ctrl_d = {CTRL_W{1'b0}};
                    end else begin
                        state_d = ST_ONE;
                    end
                end
                ST_FULL: begin
                    if (out_fire_s) begin
                        state_d  = ST_ONE;
                        m_data_d = s_data_q;
                        m_ctrl_d = s_ctrl_q;
                        s_ctrl_d = {CTRL_W{1'b0}};
                    end else begin
                        state_d = ST_FULL;
                    end
                end
                default: begin
                    state_d  = ST_EMPTY;
                    m_ctrl_d = {CTRL_W{1'b0}};
                    s_ctrl_d = {CTRL_W{1'b0}};
                end
            endcase
        end
    end

    // Event counters: clear wins; a cycle with both stall and flush is a flush event.
    always_comb begin
        if (cnt_clr_i) begin
            stall_cnt_d = {CNT_W{1'b0}};
        end else if (stall_i && !flush_i) begin
            stall_cnt_d = sat_inc(stall_cnt_q);
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
        if (cnt_clr_i) begin
            flush_cnt_d = {CNT_W{1'b0}};
        end else if (flush_i && m_valid_s) begin
            flush_cnt_d = sat_inc(flush_cnt_q);
        end else begin
            flush_cnt_d = flush_cnt_q;
        end
    end

    // State registers with asynchronous clear of every entry and counter.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_EMPTY;
            m_data_q    <= {DATA_W{1'b0}};
            m_ctrl_q    <= {CTRL_W{1'b0}};
            s_data_q    <= {DATA_W{1'b0}};
            s_ctrl_q    <= {CTRL_W{1'b0}};
            stall_cnt_q <= {CNT_W{1'b0}};
            flush_cnt_q <= {CNT_W{1'b0}};
        end else begin
            state_q     <= state_d;
            m_data_q    <= m_data_d;
            m_ctrl_q    <= m_ctrl_d;
            s_data_q    <= s_data_d;
            s_ctrl_q    <= s_ctrl_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign in_ready_o  = in_ready_s;
    assign out_valid_o = m_valid_s;
    assign out_data_o  = m_data_q;
    assign out_ctrl_o  = m_ctrl_q;
    assign occupancy_o = state_q;
    assign stall_cnt_o = stall_cnt_q;
    assign flush_cnt_o = flush_cnt_q;

endmodule
